rega_multizona: RTL and testbench
=================================

// Module: rega_multizona
// PURPOSE
// Parametrised multi-zone irrigation controller, successor to the single-zone sprinkler/drip logic.
// Scans ZONES soil-moisture requests round-robin and serves one zone at a time.
// Chooses sprinkler or drip per zone, times each irrigation, and manages the tank inlet valve.
// Validates the tank level code and drives the alarm. Sits under the top level beside the display and matrix modules.
// PARAMETERS
// ZONES     4   number of irrigation zones (>=2)
// TICK_DIV  50000000  clock cycles per timing tick (>=2)
// ASP_TIME  30  sprinkler run length, ticks
// GOT_TIME  60  drip run length, ticks
// GAP_TIME  2   dead time between zones, ticks (>=1)
// CNT_W     8   timer width; must hold max(ASP_TIME,GOT_TIME)
// PORTS
// clock           in   1              system clock, rising edge
// Rst             in   1              synchronous reset, active-low
// H, M, L         in   1              tank level sensors: high, medium, low (1 = water present)
// Us              in   ZONES          per-zone dry-soil request (1 = needs water)
// Ua              in   1              dry-air flag
// T               in   1              high-temperature flag
// Ve              out  1              tank inlet valve
// Al              out  1              alarm
// Bs              out  1              sprinkler pump
// Vs              out  1              drip valve
// Zona_sel        out  ZONES          one-hot zone valve, 0 when no zone active
// Zona_idx        out  $clog2(ZONES)  index of active/last-served zone
// Tempo_restante  out  CNT_W          ticks remaining, 0 outside IRRIGA
// Ocupado         out  1              1 in IRRIGA or PAUSA
// BEHAVIOUR
// - All inputs are synchronous to clock (synchronised upstream). All outputs are registered.
// - Reset (Rst=0 at an edge) has priority over everything, including mid-irrigation:
//   - state=OCIOSO; prescaler=0; rr pointer=0.
//   - All outputs 0.
// - Tick: the prescaler counts 0..TICK_DIV-1; tick=1 for one cycle when it wraps. The prescaler is never reset by the FSM.
// - Level decode of {H,M,L}:
//   - 000 critical, 001 low, 011 medium, 111 high.
//   - Any other code sets ERRO.
// - Al=1 when ERRO or critical.
// - Ve (hysteresis):
//   - Set when M=0.
//   - Cleared when H=1.
//   - Holds otherwise.
//   - Forced 0 while ERRO.
// - Mode, latched at zone start:
//   - Sprinkler (Bs) if T=0 and Ua=0.
//   - Otherwise drip (Vs).
// - Water requirement: sprinkler needs M=1; drip needs L=1.
// - FSM:
//   - OCIOSO: each cycle, search from pointer upward (mod ZONES) for the first zone with Us=1.
//     - If one is found and its mode requirement is met, latch the zone and mode, load the timer (ASP_TIME or GOT_TIME) and go to IRRIGA.
//     - Outputs asserted the next cycle, i.e. 1 cycle after Us seen.
//     - If the requirement is not met, stay in OCIOSO with the pointer unchanged.
//   - IRRIGA: Zona_sel and Bs/Vs are on; timer decrements on tick. Exit to PAUSA, loading the gap counter with GAP_TIME, when any of:
//     - the timer is 1 at a tick;
//     - Us of the active zone = 0 (early stop);
//     - the requirement is lost.
//     - Exiting sets pointer = active zone + 1 mod ZONES.
//   - PAUSA: valves off; gap counter decrements on tick; at 0 go to OCIOSO.
//   - ERRO state: entered from any state when the level code is invalid; all valves and Ve off, Al=1.
//     - Returns to OCIOSO at the first tick where the code is valid.
//     - Pointer is retained; an interrupted zone is not resumed.
// - Simultaneous events:
//   - ERRO beats timer expiry and early stop.
//   - Early stop and expiry in the same cycle give a single exit.
//   - Zona_sel is never multi-hot. Bs and Vs are never both 1.
// TESTING (bench: ZONES=4, TICK_DIV=4, ASP_TIME=5, GOT_TIME=8, GAP_TIME=2)
// 1. HML=111, T=0, Ua=0, Us=0100 -> next cycle Zona_sel=0100, Bs=1, Tempo_restante=5. Off after 5 ticks, then 2-tick PAUSA.
// 2. Us=1111 held, HML=111, T=1 -> zones served 0,1,2,3,0 in order, each Vs=1 for 8 ticks.
// 3. HML=001, T=0, Ua=0, Us=0001 -> stays OCIOSO; Ve=1. Set T=1 -> drip starts on zone 0.
// 4. Irrigating zone 2, drop Us[2] at tick 3 -> Bs=0 and Zona_sel=0 next cycle, pointer=3.
// 5. Mid-irrigation drive HML=101 -> next cycle all valves and Ve off, Al=1. Restore 111 -> OCIOSO at next tick.
// 6. Rst=0 mid-irrigation for 1 cycle -> all outputs 0, next service starts at zone 0. Ve: M=0 -> 1, holds through M=1, clears at H=1.

Source files
------------

// File: rtl/rega_multizona_if.sv
// rtl/rega_multizona_if.sv - Sensor inputs and valve/status outputs of the multi-zone irrigation controller
interface rega_multizona_if #(
  parameter int ZONES = 4,
  parameter int CNT_W = 8
);
  localparam int IDX_W = $clog2(ZONES);

  logic             H, M, L;
  logic [ZONES-1:0] Us;
  logic             Ua, T;
  logic             Ve, Al, Bs, Vs;
  logic [ZONES-1:0] Zona_sel;
  logic [IDX_W-1:0] Zona_idx;
  logic [CNT_W-1:0] Tempo_restante;
  logic             Ocupado;

  modport master (
    output H, M, L, Us, Ua, T,
    input  Ve, Al, Bs, Vs, Zona_sel, Zona_idx, Tempo_restante, Ocupado
  );

  modport slave (
    input  H, M, L, Us, Ua, T,
    output Ve, Al, Bs, Vs, Zona_sel, Zona_idx, Tempo_restante, Ocupado
  );
endinterface

// File: rtl/rega_multizona.sv
// rtl/rega_multizona.sv - Round-robin multi-zone irrigation FSM with tank inlet hysteresis and level alarm
module rega_multizona #(
  parameter int ZONES    = 4,
  parameter int TICK_DIV = 50000000,
  parameter int ASP_TIME = 30,
  parameter int GOT_TIME = 60,
  parameter int GAP_TIME = 2,
  parameter int CNT_W    = 8
) (
  input  logic           clock,
  input  logic           Rst,
  rega_multizona_if.slave bus
);
  localparam int IDX_W = $clog2(ZONES);
  localparam int PW    = $clog2(TICK_DIV);

  typedef enum logic [1:0] {OCIOSO, IRRIGA, PAUSA, ERRO} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q;
  logic [IDX_W-1:0] ptr_q, ptr_d, zone_q, zone_d, cand;
  logic             spr_q, spr_d;
  logic [CNT_W-1:0] tmr_q, tmr_d, gap_q, gap_d, rem_q, rem_d;
  logic             ve_q, ve_d, al_q, al_d, bs_q, bs_d, vs_q, vs_d, ocup_q, ocup_d;
  logic [ZONES-1:0] sel_q, sel_d;
  logic [2:0]       hml;
  logic             tick, lvl_ok, crit, spr_now, req_now, req_act, found;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= ZONES) s = s - ZONES;
    return IDX_W'(s);
  endfunction

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign hml     = {bus.H, bus.M, bus.L};
  assign lvl_ok  = hml inside {3'b000, 3'b001, 3'b011, 3'b111};
  assign crit    = (hml == 3'b000);
  assign spr_now = !bus.T && !bus.Ua;
  assign req_now = spr_now ? bus.M : bus.L;
  assign req_act = spr_q ? bus.M : bus.L;

  // Scan downward so the last hit, i.e. the one closest above the pointer, wins.
  always_comb begin
    found = 1'b0;
    cand  = ptr_q;
    for (int i = ZONES - 1; i >= 0; i--) begin
      if (bus.Us[wrap_add(ptr_q, i)]) begin
        found = 1'b1;
        cand  = wrap_add(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    zone_d  = zone_q;
    spr_d   = spr_q;
    tmr_d   = tmr_q;
    gap_d   = gap_q;
    if (!lvl_ok) begin
      state_d = ERRO;
    end else begin
      case (state_q)
        OCIOSO: if (found && req_now) begin
          state_d = IRRIGA;
          zone_d  = cand;
          spr_d   = spr_now;
          tmr_d   = spr_now ? CNT_W'(ASP_TIME) : CNT_W'(GOT_TIME);
        end
        IRRIGA: begin
          if (!bus.Us[zone_q] || !req_act || (tick && tmr_q == CNT_W'(1))) begin
            state_d = PAUSA;
            gap_d   = CNT_W'(GAP_TIME);
            ptr_d   = wrap_add(zone_q, 1);
          end else if (tick) begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        PAUSA: begin
          if (gap_q == '0) state_d = OCIOSO;
          else if (tick)   gap_d   = gap_q - 1'b1;
        end
        default: if (tick) state_d = OCIOSO;
      endcase
    end

    // Inlet hysteresis: open below medium, close at high, hold in between.
    ve_d = ve_q;
    if (!bus.M) ve_d = 1'b1;
    if (bus.H)  ve_d = 1'b0;
    if (state_d == ERRO) ve_d = 1'b0;

    al_d   = (state_d == ERRO) || crit;
    bs_d   = (state_d == IRRIGA) && spr_d;
    vs_d   = (state_d == IRRIGA) && !spr_d;
    sel_d  = (state_d == IRRIGA) ? (ZONES'(1) << zone_d) : '0;
    rem_d  = (state_d == IRRIGA) ? tmr_d : '0;
    ocup_d = (state_d == IRRIGA) || (state_d == PAUSA);
  end

  always_ff @(posedge clock) begin
    if (!Rst) begin
      state_q <= OCIOSO;
      presc_q <= '0;
      ptr_q   <= '0;
      zone_q  <= '0;
      spr_q   <= 1'b0;
      tmr_q   <= '0;
      gap_q   <= '0;
      ve_q    <= 1'b0;
      al_q    <= 1'b0;
      bs_q    <= 1'b0;
      vs_q    <= 1'b0;
      sel_q   <= '0;
      rem_q   <= '0;
      ocup_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= tick ? '0 : presc_q + 1'b1;
      ptr_q   <= ptr_d;
      zone_q  <= zone_d;
      spr_q   <= spr_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
      ve_q    <= ve_d;
      al_q    <= al_d;
      bs_q    <= bs_d;
      vs_q    <= vs_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      ocup_q  <= ocup_d;
    end
  end

  assign bus.Ve             = ve_q;
  assign bus.Al             = al_q;
  assign bus.Bs             = bs_q;
  assign bus.Vs             = vs_q;
  assign bus.Zona_sel       = sel_q;
  assign bus.Zona_idx       = zone_q;
  assign bus.Tempo_restante = rem_q;
  assign bus.Ocupado        = ocup_q;
endmodule

// File: tb/tb_rega_multizona.sv
// tb/tb_rega_multizona.sv - Scoreboard bench for rega_multizona
module tb_rega_multizona;
  localparam int ZONES = 4, TICK_DIV = 4, ASP_TIME = 5, GOT_TIME = 8, GAP_TIME = 2, CNT_W = 8;

  typedef struct packed {
    logic [1:0] zone;
    logic       spr;
    logic [7:0] tempo;
    logic       full;
  } exp_t;

  logic clock = 1'b0;
  logic Rst;
  always #5 clock = ~clock;

  rega_multizona_if #(.ZONES(ZONES), .CNT_W(CNT_W)) bus ();

  rega_multizona #(
    .ZONES(ZONES), .TICK_DIV(TICK_DIV), .ASP_TIME(ASP_TIME),
    .GOT_TIME(GOT_TIME), .GAP_TIME(GAP_TIME), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .Rst  (Rst),
    .bus  (bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_starts = 0;
  logic mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int zone, input bit spr, input bit full);
    exp_t e;
    e.zone  = 2'(zone);
    e.spr   = spr;
    e.tempo = spr ? 8'(ASP_TIME) : 8'(GOT_TIME);
    e.full  = full;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic set_lvl(input logic h, input logic m, input logic l);
    bus.H = h;
    bus.M = m;
    bus.L = l;
  endtask

  task automatic wait_starts(input int target, input int bound, input string tag);
    int k = 0;
    while (n_starts < target && k < bound) begin
      step(1);
      k++;
    end
    check_eq({tag, "_start_seen"}, n_starts >= target, 1);
  endtask

  task automatic wait_sel_off(input int bound, input string tag);
    int k = 0;
    while (bus.Zona_sel != 0 && k < bound) begin
      step(1);
      k++;
    end
    check_eq({tag, "_sel_off"}, bus.Zona_sel, 0);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int k = 0;
    while (bus.Ocupado && k < bound) begin
      step(1);
      k++;
    end
    check_eq({tag, "_idle"}, bus.Ocupado, 0);
  endtask

  // Monitor: a rising Zona_sel is a service start and is matched against the queue head.
  exp_t             cur;
  logic [ZONES-1:0] prev_sel = '0;
  int               run_len  = 0;
  always @(negedge clock) begin
    if (mon_en) begin
      check_eq("bs_vs_exclusive", bus.Bs & bus.Vs, 0);
      check_eq("sel_onehot0", $onehot0(bus.Zona_sel), 1);
      if (bus.Zona_sel != 0 && prev_sel == 0) begin
        n_starts++;
        run_len = 0;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_start_sel", bus.Zona_sel, 0);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
          check_eq("start_sel", bus.Zona_sel, 32'(1) << cur.zone);
          check_eq("start_idx", bus.Zona_idx, cur.zone);
          check_eq("start_bs", bus.Bs, cur.spr);
          check_eq("start_vs", bus.Vs, !cur.spr);
          check_eq("start_tempo", bus.Tempo_restante, cur.tempo);
        end
      end
      if (bus.Zona_sel != 0) run_len++;
      if (bus.Zona_sel == 0 && prev_sel != 0 && cur.full)
        check_eq("run_len_in_range",
                 (run_len >= (int'(cur.tempo) - 1) * TICK_DIV + 1) &&
                 (run_len <= int'(cur.tempo) * TICK_DIV), 1);
      prev_sel = bus.Zona_sel;
    end
  end

  initial begin
    int base;
    int k;

    // Reset with inputs that would otherwise raise Al and Ve.
    Rst    = 1'b0;
    set_lvl(0, 0, 0);
    bus.Us = '0;
    bus.Ua = 1'b0;
    bus.T  = 1'b0;
    step(2);
    check_eq("reset_outputs", {bus.Ve, bus.Al, bus.Bs, bus.Vs, bus.Ocupado,
                               bus.Zona_sel, bus.Zona_idx, bus.Tempo_restante}, 0);
    set_lvl(1, 1, 1);
    Rst    = 1'b1;
    mon_en = 1'b1;

    // 1: single sprinkler zone, full run then gap.
    push_exp(2, 1, 1);
    bus.Us = 4'b0100;
    wait_starts(1, 3, "t1");
    wait_sel_off(30, "t1");
    bus.Us = '0;
    k = 0;
    while (bus.Ocupado && k < 20) begin
      k++;
      step(1);
    end
    check_eq("t1_pausa_len", (k >= GAP_TIME * TICK_DIV) && (k <= GAP_TIME * TICK_DIV + 1), 1);

    // 2: round robin of drip zones from pointer 0.
    Rst = 1'b0;
    step(1);
    Rst   = 1'b1;
    bus.T = 1'b1;
    for (int z = 0; z < 5; z++) push_exp(z % ZONES, 0, 1);
    base   = n_starts;
    bus.Us = 4'b1111;
    wait_starts(base + 5, 300, "t2");
    wait_sel_off(40, "t2");
    bus.Us = '0;
    wait_idle(20, "t2");

    // 3: sprinkler blocked at low level, drip allowed.
    bus.T = 1'b0;
    set_lvl(0, 0, 1);
    bus.Us = 4'b0001;
    step(12);
    check_eq("t3_blocked_ocup", bus.Ocupado, 0);
    check_eq("t3_blocked_sel", bus.Zona_sel, 0);
    check_eq("t3_ve_low", bus.Ve, 1);
    check_eq("t3_al_low", bus.Al, 0);
    push_exp(0, 0, 0);
    base  = n_starts;
    bus.T = 1'b1;
    wait_starts(base + 1, 3, "t3");
    check_eq("t3_vs_on", bus.Vs, 1);
    bus.Us = '0;
    wait_idle(30, "t3");

    // 4: early stop of zone 2 moves the pointer to 3.
    set_lvl(1, 1, 1);
    bus.T = 1'b0;
    step(2);
    push_exp(2, 1, 0);
    base   = n_starts;
    bus.Us = 4'b0100;
    wait_starts(base + 1, 3, "t4");
    k = 0;
    while (bus.Tempo_restante != 2 && k < 20) begin
      step(1);
      k++;
    end
    check_eq("t4_tempo_after_3_ticks", bus.Tempo_restante, 2);
    bus.Us = '0;
    step(1);
    check_eq("t4_bs_off", bus.Bs, 0);
    check_eq("t4_sel_off", bus.Zona_sel, 0);
    check_eq("t4_tempo_zero", bus.Tempo_restante, 0);
    check_eq("t4_pausa_busy", bus.Ocupado, 1);
    check_eq("t4_idx_kept", bus.Zona_idx, 2);
    wait_idle(20, "t4");
    push_exp(3, 1, 0);
    base   = n_starts;
    bus.Us = 4'b1100;
    wait_starts(base + 1, 3, "t4b");
    bus.Us = '0;
    wait_idle(20, "t4b");

    // 5: invalid level code mid-irrigation.
    push_exp(0, 1, 0);
    base   = n_starts;
    bus.Us = 4'b0001;
    wait_starts(base + 1, 3, "t5");
    step(2);
    set_lvl(1, 0, 1);
    step(1);
    check_eq("t5_err_sel", bus.Zona_sel, 0);
    check_eq("t5_err_bs", bus.Bs, 0);
    check_eq("t5_err_vs", bus.Vs, 0);
    check_eq("t5_err_ve", bus.Ve, 0);
    check_eq("t5_err_al", bus.Al, 1);
    check_eq("t5_err_ocup", bus.Ocupado, 0);
    bus.Us = '0;
    step(6);
    check_eq("t5_err_hold_al", bus.Al, 1);
    check_eq("t5_err_hold_ve", bus.Ve, 0);
    set_lvl(1, 1, 1);
    k = 0;
    while (bus.Al && k < 8) begin
      step(1);
      k++;
    end
    check_eq("t5_recover_at_tick", (k >= 1) && (k <= TICK_DIV), 1);
    push_exp(0, 1, 0);
    push_exp(1, 1, 0);
    base   = n_starts;
    bus.Us = 4'b0011;
    wait_starts(base + 1, 3, "t5_ptr_kept");
    bus.Us = 4'b0010;
    wait_starts(base + 2, 20, "t5_next");

    // 6: reset mid-irrigation restarts scanning at zone 0; then inlet hysteresis.
    bus.Us = 4'b0111;
    Rst    = 1'b0;
    step(1);
    check_eq("t6_reset_outputs", {bus.Ve, bus.Al, bus.Bs, bus.Vs, bus.Ocupado,
                                  bus.Zona_sel, bus.Zona_idx, bus.Tempo_restante}, 0);
    push_exp(0, 1, 0);
    base = n_starts;
    Rst  = 1'b1;
    wait_starts(base + 1, 3, "t6");
    bus.Us = '0;
    wait_idle(20, "t6");
    check_eq("t6_ve_high", bus.Ve, 0);
    set_lvl(0, 1, 1);
    step(2);
    check_eq("t6_ve_hold_off", bus.Ve, 0);
    set_lvl(0, 0, 1);
    step(1);
    check_eq("t6_ve_set", bus.Ve, 1);
    set_lvl(0, 1, 1);
    step(2);
    check_eq("t6_ve_hold_on", bus.Ve, 1);
    set_lvl(0, 0, 0);
    step(1);
    check_eq("t6_crit_al", bus.Al, 1);
    check_eq("t6_crit_ve", bus.Ve, 1);
    set_lvl(1, 1, 1);
    step(1);
    check_eq("t6_ve_clear", bus.Ve, 0);
    check_eq("t6_al_clear", bus.Al, 0);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
